// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch types and constants
package cpu_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int INSTR_BYTES = 4;

  typedef enum logic {FETCH, FLUSH} fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch queue, synchronous FIFO with combinational head
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter type entry_t = logic [31:0],
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  entry_t      push_data,
  input  logic        pop,
  input  logic        flush,
  output entry_t      head,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);
  entry_t      mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic        do_push, do_pop;

  // Extra pointer bit tells full from empty when the index bits match.
  assign count   = wptr - rptr;
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end: PC, request credits, flush FSM
module fetch_unit #(
  parameter int XLEN = cpu_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [CW-1:0]   q_count
);
  import cpu_pkg::*;

  fetch_state_t    state, state_next;
  logic [XLEN-1:0] fetch_pc, rsp_pc, redirect_aligned;
  logic [CW-1:0]   outstanding, outstanding_next;
  logic [CW:0]     credit_used;
  logic            req_fire, rsp_fire, push, empty, full;
  fetch_entry_t    push_entry, head;

  // Requests in flight plus buffered words never exceed the queue size.
  assign credit_used      = {1'b0, outstanding} + {1'b0, q_count};
  assign imem_req_valid   = (state == FETCH) && !rst && (credit_used < (CW+1)'(DEPTH));
  assign imem_req_addr    = fetch_pc;
  assign req_fire         = imem_req_valid && imem_req_ready;
  assign rsp_fire         = imem_rsp_valid;
  assign outstanding_next = outstanding + CW'(req_fire) - CW'(rsp_fire);
  assign push             = rsp_fire && (state == FETCH) && !redirect_valid;
  assign redirect_aligned = redirect_pc & ~XLEN'(3);
  assign push_entry.pc    = rsp_pc;
  assign push_entry.instr = imem_rsp_data;

  fetch_fifo #(.DEPTH(DEPTH), .entry_t(fetch_entry_t)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (out_ready),
    .flush     (redirect_valid),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (q_count)
  );

  assign out_valid = !empty;
  assign out_instr = empty ? NOP_INSTR : head.instr;
  assign out_pc    = empty ? '0 : head.pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (redirect_valid)
      state_next = (outstanding_next != '0) ? FLUSH : FETCH;
    else if (state == FLUSH && outstanding_next == '0)
      state_next = FETCH;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_VECTOR;
      rsp_pc      <= RESET_VECTOR;
      outstanding <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (redirect_valid) begin
        fetch_pc <= redirect_aligned;
        rsp_pc   <= redirect_aligned;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + XLEN'(INSTR_BYTES);
        if (push)     rsp_pc   <= rsp_pc + XLEN'(INSTR_BYTES);
      end
    end
  end

  // Memory must not answer without a pending request; credits keep the queue from overflowing.
  always_ff @(posedge clk) begin
    if (!rst && rsp_fire) assert (outstanding != '0);
    if (!rst && push && full) assert (out_ready);
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized bench for fetch_unit with program-order reference model
module tb_fetch_unit;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, rsp_valid, redirect_valid, out_valid, out_ready;
  logic [31:0] req_addr, rsp_data, redirect_pc, out_instr, out_pc;
  logic [2:0]  q_count;
  logic        req_valid1, out_valid1;
  logic [31:0] req_addr1, out_instr1, out_pc1;
  logic [2:0]  q_count1;

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(32), .RESET_VECTOR(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .q_count(q_count)
  );

  // Second instance: alternate reset vector, memory never answers.
  fetch_unit #(.XLEN(32), .RESET_VECTOR(32'h8000_0000), .DEPTH(DEPTH)) dut1 (
    .clk(clk), .rst(rst),
    .imem_req_valid(req_valid1), .imem_req_ready(1'b1), .imem_req_addr(req_addr1),
    .imem_rsp_valid(1'b0), .imem_rsp_data(32'h0),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .out_valid(out_valid1), .out_ready(1'b0), .out_instr(out_instr1), .out_pc(out_pc1),
    .q_count(q_count1)
  );

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } mreq_t;

  mreq_t       memq[$];
  logic [31:0] pq[$];
  logic [31:0] exp_req, exp_req1;
  int          n1, epoch, cyc;
  int          ready_pct, out_ready_pct, lat_min, lat_max;
  int          vectors, miscompares;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check outputs at negedge, advance the model across the edge.
  task automatic run_cycle(input logic redir, input logic [31:0] tgt);
    logic  rs, rf, of, exp_rv;
    int    stale;
    mreq_t h;
    h         = '{32'h0, -1, 0};
    req_ready = ($urandom_range(99) < ready_pct);
    out_ready = ($urandom_range(99) < out_ready_pct);
    rs        = (memq.size() > 0) && (memq[0].due <= cyc);
    rsp_valid = rs;
    rsp_data  = rs ? word_at(memq[0].addr) : $urandom;
    redirect_valid = redir;
    redirect_pc    = tgt;
    @(negedge clk);
    stale = 0;
    foreach (memq[i]) if (memq[i].epoch != epoch) stale++;
    exp_rv = (stale == 0) && (memq.size() + pq.size() < DEPTH);
    chk("req_valid", 32'(req_valid), 32'(exp_rv));
    if (exp_rv) chk("req_addr", req_addr, exp_req);
    chk("out_valid", 32'(out_valid), 32'(pq.size() > 0));
    chk("out_pc", out_pc, (pq.size() > 0) ? pq[0] : 32'h0);
    chk("out_instr", out_instr, (pq.size() > 0) ? word_at(pq[0]) : 32'h0);
    chk("q_count", 32'(q_count), 32'(pq.size()));
    chk("req_valid1", 32'(req_valid1), 32'(n1 < DEPTH));
    if (n1 < DEPTH) chk("req_addr1", req_addr1, exp_req1);
    rf = req_valid && req_ready;
    of = out_valid && out_ready;
    if (rs) h = memq.pop_front();
    if (of && pq.size() > 0) void'(pq.pop_front());
    if (rs && h.epoch == epoch && !redir) pq.push_back(h.addr);
    if (rf) begin
      memq.push_back('{exp_req, epoch, cyc + int'($urandom_range(lat_max, lat_min))});
      exp_req += 32'd4;
    end
    if (redir) begin
      pq.delete();
      epoch++;
      exp_req = tgt & ~32'h3;
    end
    if (req_valid1) begin
      n1++;
      exp_req1 += 32'd4;
    end
    @(posedge clk);
    #1;
    cyc++;
    redirect_valid = 1'b0;
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, 32'h0);
  endtask

  task automatic model_reset();
    memq.delete();
    pq.delete();
    epoch++;
    exp_req  = 32'h0000_0000;
    exp_req1 = 32'h8000_0000;
    n1       = 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_req_valid"}, 32'(req_valid), 32'h0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'h0);
    chk({tag, "_out_instr"}, out_instr, 32'h0);
    chk({tag, "_out_pc"}, out_pc, 32'h0);
    chk({tag, "_q_count"}, 32'(q_count), 32'h0);
    chk({tag, "_req_valid1"}, 32'(req_valid1), 32'h0);
  endtask

  initial begin
    int budget;
    vectors = 0; miscompares = 0; epoch = 0; cyc = 0;
    rst = 1'b1; req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    ready_pct = 100; out_ready_pct = 100; lat_min = 1; lat_max = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    // Streaming, 1-cycle memory, decode always ready.
    run_n(12);

    // Decode stalls: queue fills to DEPTH and requests stop.
    out_ready_pct = 0;
    run_n(20);
    chk("stall_q_count", 32'(q_count), 32'd4);
    chk("stall_req_valid", 32'(req_valid), 32'h0);
    out_ready_pct = 100;
    run_n(10);

    // Redirect with two responses in flight on a 3-cycle memory.
    lat_min = 3; lat_max = 3;
    budget = 0;
    while (memq.size() != 2 && budget < 20) begin run_cycle(1'b0, 32'h0); budget++; end
    chk("flush_outstanding", 32'(memq.size()), 32'd2);
    run_cycle(1'b1, 32'h0000_0100);
    run_n(15);

    // Redirect coinciding with a live response and an out handshake.
    lat_min = 1; lat_max = 2;
    budget = 0;
    while (!(memq.size() > 0 && memq[0].due <= cyc && memq[0].epoch == epoch && pq.size() > 0)
           && budget < 30) begin
      run_cycle(1'b0, 32'h0);
      budget++;
    end
    chk("coincide_found", 32'(budget < 30), 32'h1);
    run_cycle(1'b1, 32'h0000_0203);
    run_n(10);

    // Second redirect while still flushing.
    lat_min = 3; lat_max = 3;
    budget = 0;
    while (memq.size() < 2 && budget < 20) begin run_cycle(1'b0, 32'h0); budget++; end
    chk("flush2_outstanding", 32'(memq.size() >= 2), 32'h1);
    run_cycle(1'b1, 32'h0000_0200);
    run_cycle(1'b1, 32'h0000_0300);
    run_n(15);

    // Randomized traffic with sporadic redirects.
    ready_pct = 70; out_ready_pct = 60; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 300; i++)
      run_cycle($urandom_range(99) < 5, $urandom & 32'h0000_0FFF);

    // PC wrap at the top of the address space.
    ready_pct = 100; out_ready_pct = 100; lat_min = 1; lat_max = 1;
    run_cycle(1'b1, 32'hFFFF_FFF6);
    run_n(12);

    // Asynchronous reset with a full queue.
    out_ready_pct = 0;
    run_n(12);
    chk("prereset_q_count", 32'(q_count), 32'd4);
    #2;
    rst = 1'b1;
    #1;
    check_zero("async_reset");
    model_reset();
    rsp_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;
    out_ready_pct = 100;
    run_n(12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end: the next generation of the single-cycle fetch path.
- Owns the PC and issues requests to an instruction memory with variable latency, using a valid/ready handshake and in-order responses.
- Buffers returned words with their PCs in a prefetch queue and presents them to decode through a valid/ready handshake.
- Supports redirects (branch, jump, trap), which flush the queue and discard in-flight responses.

Parameters:
- XLEN, 32, PC and address width.
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset. Width is XLEN.
- DEPTH, 4, prefetch queue depth. Must be a power of 2 and at least 2. It also bounds outstanding requests.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  XLEN  fetch address, word aligned.
- imem_rsp_valid  in  1  response valid. Responses arrive in order, at least 1 cycle after request acceptance, and cannot be back-pressured.
- imem_rsp_data  in  32  returned instruction word.
- redirect_valid  in  1  single-cycle redirect pulse.
- redirect_pc  in  XLEN  redirect target.
- out_valid  out  1  instruction available to decode.
- out_ready  in  1  decode accepts the instruction.
- out_instr  out  32  instruction word. Reads 32'h0000_0000 when out_valid=0.
- out_pc  out  XLEN  PC of out_instr. Reads 0 when out_valid=0.
- q_count  out  $clog2(DEPTH)+1  queue occupancy.

Behaviour:
- Reset (asynchronous, active-high). On assertion:
  - fetch_pc=RESET_VECTOR and rsp_pc=RESET_VECTOR.
  - outstanding=0, queue empty, state=FETCH.
  - imem_req_valid=0, out_valid=0, out_instr=0, out_pc=0, q_count=0.
  - Reset mid-operation abandons all in-flight requests. Responses arriving after reset deasserts are a memory-side protocol error and are not handled.
- Handshake events:
  - req_fire = imem_req_valid & imem_req_ready.
  - out_fire = out_valid & out_ready.
  - rsp_fire = imem_rsp_valid. Only legal when outstanding>0; guard with an assertion.
- Credit rule: imem_req_valid = (state==FETCH) & !rst & (outstanding + q_count < DEPTH). This guarantees the queue never overflows.
- Request address: imem_req_addr = fetch_pc.
  - While valid & !ready, the address holds stable.
  - A redirect may withdraw or change a pending, unaccepted request.
- req_fire:
  - fetch_pc += 4, wrapping modulo 2^XLEN.
  - outstanding += 1.
- rsp_fire:
  - outstanding -= 1.
  - In FETCH: push {rsp_pc, imem_rsp_data} into the queue and set rsp_pc += 4.
  - In FLUSH: discard the response.
- Queue: FIFO of {pc, instr}.
  - out_valid = !empty. The head is shown combinationally.
  - A write into an empty queue appears on out_* the next cycle (minimum fetch-to-decode latency is request cycle + memory latency + 1).
  - A simultaneous push and pop at full or empty is legal. Occupancy is unchanged except for an empty push (+1).
- State machine: FETCH, FLUSH.
  - FETCH -> FLUSH on redirect_valid when outstanding_next > 0.
  - FETCH -> FETCH on redirect_valid when outstanding_next = 0.
  - FLUSH -> FETCH when outstanding_next = 0.
  - FLUSH issues no requests.
  - Here, outstanding_next = outstanding + req_fire - rsp_fire.
- On redirect_valid, in either state:
  - fetch_pc = rsp_pc = {redirect_pc[XLEN-1:2], 2'b00}.
  - The queue is emptied.
  - q_count=0 and out_valid=0 the next cycle.
- Simultaneous events with redirect:
  - Redirect + out_fire in the same cycle: the handshake completes; decode owns that instruction.
  - Redirect + rsp_fire in the same cycle: the response is discarded.
  - Redirect + req_fire in the same cycle: the request counts as outstanding, so its response is discarded in FLUSH.
  - Redirect during FLUSH: the PC is retargeted and the state stays FLUSH until outstanding reaches 0.
- Counters: outstanding is $clog2(DEPTH)+1 bits and never exceeds DEPTH.

Decomposition:
- cpu_pkg additions:
  - fetch_state_t enum {FETCH, FLUSH}.
  - fetch_entry_t packed struct {pc, instr}, with the pc field XLEN wide (fix XLEN as a package parameter).
  - NOP_INSTR = 32'h0000_0000.
  - INSTR_BYTES = 4.
- Sub-module fetch_fifo:
  - Parametrised synchronous FIFO with DEPTH and entry type.
  - Ports: push/pop/flush, full/empty/count.
  - Async active-high reset.
  - Pointer wrap uses one extra bit.
- fetch_unit holds the PC, counters and FSM.

Test Plan:
- Reset release, 1-cycle-latency memory always ready, out_ready=1 -> request addresses 0x0,0x4,0x8,...; out_pc follows 0x0,0x4,... with matching words; first out_valid 2 cycles after the first req_fire.
- out_ready=0 for 20 cycles, DEPTH=4 -> exactly 4 requests issued, q_count=4, imem_req_valid=0; when out_ready=1, draining resumes with no loss or duplication.
- Memory latency 3, redirect_pc=0x100 with 2 outstanding -> FLUSH; both stale responses dropped; next request addr 0x100 only after outstanding=0; next out_pc=0x100.
- Redirect same cycle as rsp_fire and out_fire, target 0x203 -> the out instruction is consumed, the response is dropped, and the next fetch address is 0x200.
- Second redirect to 0x300 while in FLUSH -> no request until drained; first fetched address is 0x300, never 0x200-series.
- rst asserted mid-stream with queue full -> all outputs 0 immediately (asynchronous); after release, fetch restarts at RESET_VECTOR (rerun with RESET_VECTOR=32'h8000_0000); also check fetch_pc wrap at 0xFFFF_FFFC -> 0x0.
